// File: rtl/ca3_defs.sv
// Shared definitions for the 8-bit accumulator CPU control unit:
// opcodes, ALU operations, controller states and instruction field positions.
package ca3_defs;

    localparam int unsigned OPC_W = 3;
    localparam int unsigned ALU_W = 2;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_JZ  = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    typedef enum logic [1:0] {
        S_IF1 = 2'b00,
        S_IF2 = 2'b01,
        S_DEC = 2'b10,
        S_MEM = 2'b11
    } state_e;

    // IR = {byte0, byte1}; byte0 = {opcode, addr[12:8]}, byte1 = addr[7:0]
    localparam int unsigned IR_W        = 16;
    localparam int unsigned IR_OPC_MSB  = 15;
    localparam int unsigned IR_OPC_LSB  = 13;
    localparam int unsigned IR_ADDR_MSB = 12;
    localparam int unsigned IR_ADDR_LSB = 0;

endpackage

// File: rtl/ca3_controller.sv
// Multicycle control unit for the accumulator CPU: fetch (two bytes), decode,
// optional memory access, with req/ack memory handshake.
module ca3_controller
    import ca3_defs::*;
#(
    parameter int unsigned OPC_W = 3,
    parameter int unsigned ALU_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             acc_zero,
    input  logic             mem_ack,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             adr_sel,
    output logic             pc_src,
    output logic             pc_wr,
    output logic             ir_hi_wr,
    output logic             ir_lo_wr,
    output logic             acc_sel,
    output logic             acc_wr,
    output logic [ALU_W-1:0] alu_op
);

    state_e state_q, state_d;
    // Cleared asynchronously by reset and set on the first edge after release,
    // so outputs drop immediately on reset and start issuing on that edge.
    logic   run_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IF1;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        adr_sel  = 1'b0;
        pc_src   = 1'b0;
        pc_wr    = 1'b0;
        ir_hi_wr = 1'b0;
        ir_lo_wr = 1'b0;
        acc_sel  = 1'b0;
        acc_wr   = 1'b0;
        alu_op   = ALU_W'(ALU_ADD);

        unique case (state_q)
            S_IF1: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    ir_hi_wr = 1'b1;
                    pc_wr    = 1'b1;
                    state_d  = S_IF2;
                end
            end
            S_IF2: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    ir_lo_wr = 1'b1;
                    pc_wr    = 1'b1;
                    state_d  = S_DEC;
                end
            end
            S_DEC: begin
                state_d = S_IF1;
                case (opcode)
                    OP_NOT: begin
                        acc_wr = 1'b1;
                        alu_op = ALU_W'(ALU_NOT);
                    end
                    OP_JMP: begin
                        pc_wr  = 1'b1;
                        pc_src = 1'b1;
                    end
                    OP_JZ: begin
                        pc_wr  = acc_zero;
                        pc_src = acc_zero;
                    end
                    default: state_d = S_MEM;
                endcase
            end
            S_MEM: begin
                adr_sel = 1'b1;
                if (opcode == OP_STA) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd  = 1'b1;
                    acc_wr  = mem_ack;
                    acc_sel = (opcode == OP_LDA);
                    case (opcode)
                        OP_SUB:  alu_op = ALU_W'(ALU_SUB);
                        OP_AND:  alu_op = ALU_W'(ALU_AND);
                        default: alu_op = ALU_W'(ALU_ADD);
                    endcase
                end
                if (mem_ack) begin
                    state_d = S_IF1;
                end
            end
            default: state_d = S_IF1;
        endcase

        if (!run_q) begin
            state_d  = S_IF1;
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            adr_sel  = 1'b0;
            pc_src   = 1'b0;
            pc_wr    = 1'b0;
            ir_hi_wr = 1'b0;
            ir_lo_wr = 1'b0;
            acc_sel  = 1'b0;
            acc_wr   = 1'b0;
            alu_op   = '0;
        end
    end

endmodule
